// File: rtl/mux16_arbiter.sv
// Round-robin arbiter for the shared 16:1 mux datapath.
// Registered one-hot grant and binary select, with hold-time pre-emption.
module mux16_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        gnt_valid,
  output logic        gnt_new
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] HMAX = 8'(MAX_HOLD);

  logic [0:0]  state;
  logic [3:0]  ptr;
  logic [7:0]  hold_cnt;

  logic        own_req;
  logic        at_max;
  logic [15:0] others;
  logic [15:0] cand;
  logic [3:0]  win;
  logic        found;
  logic        idle_st;
  logic        busy_rel;
  logic        busy_hold;
  logic        issue;
  logic        drop;

  always_comb begin
    own_req   = req[sel];
    at_max    = (hold_cnt >= HMAX);
    others    = req & ~grant;
    idle_st   = (state == IDLE);
    busy_rel  = (state == BUSY) && !own_req;
    busy_hold = (state == BUSY) && own_req;
    // A holder being pre-empted must not win its own re-arbitration
    cand      = busy_hold ? others : req;
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      automatic logic [3:0] idx = ptr + 4'(i);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    issue = 1'b0;
    drop  = 1'b0;
    unique case (1'b1)
      idle_st: issue = |req;
      busy_rel: begin
        issue = |req;
        drop  = ~|req;
      end
      busy_hold: issue = at_max && |others;
      default: begin
        issue = 1'b0;
        drop  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      gnt_new   <= 1'b0;
    end else begin
      gnt_new <= issue;
      if (issue) begin
        state     <= BUSY;
        grant     <= 16'(1) << win;
        sel       <= win;
        gnt_valid <= 1'b1;
        hold_cnt  <= 8'd1;
        ptr       <= win + 4'd1;
      end else if (drop) begin
        state     <= IDLE;
        grant     <= '0;
        gnt_valid <= 1'b0;
      end else if (busy_hold && !at_max) begin
        hold_cnt  <= hold_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Scoreboard bench for mux16_arbiter.
// Four instances with different MAX_HOLD share one stimulus stream.
module tb_mux16_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0][15:0] g;
    logic [N-1:0][3:0]  s;
    logic [N-1:0]       v;
    logic [N-1:0]       n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;

  logic [15:0] grant [N];
  logic [3:0]  sel   [N];
  logic        gv    [N];
  logic        gn    [N];

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // reference model state
  int          mh    [N];
  logic        m_busy[N];
  logic [3:0]  m_ptr [N];
  int          m_hc  [N];
  logic [15:0] m_g   [N];
  logic [3:0]  m_s   [N];
  logic        m_v   [N];
  logic        m_n   [N];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    mux16_arbiter #(
      .MAX_HOLD(k == 0 ? 8 : k == 1 ? 2 : k == 2 ? 4 : 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .grant    (grant[k]),
      .sel      (sel[k]),
      .gnt_valid(gv[k]),
      .gnt_new  (gn[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] pick(input logic [3:0] p,
                                      input logic [15:0] c);
    for (int i = 0; i < 16; i++)
      if (c[(int'(p) + i) % 16]) return 4'((int'(p) + i) % 16);
    return 4'd0;
  endfunction

  task automatic m_issue(input int k, input logic [15:0] c);
    logic [3:0] w;
    w         = pick(m_ptr[k], c);
    m_g[k]    = 16'h1 << w;
    m_s[k]    = w;
    m_v[k]    = 1'b1;
    m_n[k]    = 1'b1;
    m_hc[k]   = 1;
    m_ptr[k]  = 4'((int'(w) + 1) % 16);
    m_busy[k] = 1'b1;
  endtask

  task automatic m_step(input int k, input logic rst, input logic [15:0] r);
    if (rst) begin
      m_busy[k] = 1'b0; m_ptr[k] = 0; m_hc[k] = 0;
      m_g[k] = 0; m_s[k] = 0; m_v[k] = 0; m_n[k] = 0;
      return;
    end
    m_n[k] = 1'b0;
    if (!m_busy[k]) begin
      if (r != 0) m_issue(k, r);
    end else if (!r[m_s[k]]) begin
      if (r != 0) m_issue(k, r);
      else begin
        m_busy[k] = 1'b0; m_g[k] = 0; m_v[k] = 1'b0;
      end
    end else if (m_hc[k] == mh[k]) begin
      if ((r & ~m_g[k]) != 0) m_issue(k, r & ~m_g[k]);
    end else begin
      m_hc[k]++;
    end
  endtask

  task automatic cyc(input logic rst, input logic [15:0] r);
    exp_t e;
    exp_t o;
    @(negedge clk);
    reset = rst;
    req   = r;
    for (int k = 0; k < N; k++) begin
      m_step(k, rst, r);
      e.g[k] = m_g[k]; e.s[k] = m_s[k];
      e.v[k] = m_v[k]; e.n[k] = m_n[k];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    for (int k = 0; k < N; k++) begin
      check($sformatf("grant[%0d]", k), 32'(grant[k]), 32'(o.g[k]));
      check($sformatf("sel[%0d]", k), 32'(sel[k]), 32'(o.s[k]));
      check($sformatf("valid[%0d]", k), 32'(gv[k]), 32'(o.v[k]));
      check($sformatf("new[%0d]", k), 32'(gn[k]), 32'(o.n[k]));
      if (gv[k]) check($sformatf("onehot[%0d]", k),
                       32'(grant[k]), 32'(16'h1 << sel[k]));
      check($sformatf("reqd[%0d]", k), 32'(grant[k] & ~r), 32'h0);
    end
  endtask

  initial begin
    mh = '{8, 2, 4, 1};
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 0; m_ptr[k] = 0; m_hc[k] = 0;
      m_g[k] = 0; m_s[k] = 0; m_v[k] = 0; m_n[k] = 0;
    end
    reset = 1'b1;
    req   = 16'hFFFF;
    // reset with all requesting, then full round robin with wrap
    repeat (2) cyc(1'b1, 16'hFFFF);
    check("post_rst_grant", 32'(grant[0]), 32'h0);
    repeat (40) cyc(1'b0, 16'hFFFF);
    repeat (2) cyc(1'b0, 16'h0000);
    // single requester, then release
    repeat (3) cyc(1'b0, 16'h0020);
    repeat (2) cyc(1'b0, 16'h0000);
    check("sel_holds5", 32'(sel[0]), 32'd5);
    // lone holder saturation, then a competitor appears
    repeat (20) cyc(1'b0, 16'h0008);
    repeat (3) cyc(1'b0, 16'h1008);
    repeat (2) cyc(1'b0, 16'h0000);
    // zero-gap handoff from owner 3 to requester 1
    repeat (2) cyc(1'b0, 16'h0008);
    repeat (2) cyc(1'b0, 16'h0002);
    check("handoff_grant", 32'(grant[0]), 32'h0002);
    repeat (2) cyc(1'b0, 16'h0000);
    // reset in the middle of a grant
    repeat (3) cyc(1'b0, 16'h0200);
    cyc(1'b1, 16'h0200);
    repeat (3) cyc(1'b0, 16'h0200);
    // random traffic with occasional resets
    for (int t = 0; t < 400; t++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = 16'($urandom);
      if ($urandom_range(0, 9) == 0) r = 16'h0;
      cyc($urandom_range(0, 99) == 0, r);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Round-robin arbiter and select controller for the 16:1 combinational mux datapath. It shares the mux between 16 requesters. It grants one requester at a time and drives the registered 4-bit mux select plus a one-hot grant vector. A holder that keeps requesting while others wait is pre-empted after a bounded number of cycles.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles before pre-emption when others are waiting; legal range 1..255.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- req  in  16  request lines; requester i holds req[i]=1 for as long as it needs the mux.
- grant  out  16  one-hot grant, registered; all-zero when idle.
- sel  out  4  registered binary index of the current or last owner; drives the mux select.
- gnt_valid  out  1  1 while grant is non-zero.
- gnt_new  out  1  one-cycle pulse on the cycle a new grant first appears.

## Operation
- Internal state:
  - FSM state: IDLE or BUSY.
  - ptr[3:0]: round-robin start index.
  - hold_cnt[7:0]: cycles the current grant has been held.
- Winner selection: the first set bit of the candidate vector, scanning ascending and circularly from ptr (ptr, ptr+1, ..., 15, 0, ..., ptr-1).
- On every new grant:
  - grant = onehot(w); sel = w; gnt_valid = 1; gnt_new = 1; hold_cnt = 1.
  - ptr = (w+1) mod 16, so 15 wraps to 0.
- IDLE:
  - If req is zero: stay in IDLE; grant = 0; gnt_valid = 0; sel holds its last value.
  - If req is non-zero: pick a winner among req, issue a new grant, go to BUSY.
- BUSY, with owner o = sel:
  - req[o]=0 and req≠0: re-arbitrate among req immediately and issue a new grant. No idle cycle is inserted.
  - req[o]=0 and req=0: go to IDLE; grant = 0; gnt_valid = 0; sel keeps o.
  - req[o]=1, hold_cnt=MAX_HOLD and (req & ~grant)≠0: pre-empt; pick a winner among req & ~grant and issue a new grant.
  - req[o]=1, hold_cnt=MAX_HOLD and no other requester: keep the grant; hold_cnt saturates at MAX_HOLD.
  - Otherwise: keep the grant; hold_cnt = hold_cnt+1.
- gnt_new is 0 in every cycle that does not issue a new grant, including a continued hold by the same owner.
- Invariants:
  - grant is always zero or one-hot.
  - When gnt_valid=1, grant == onehot(sel).
  - A requester whose req is 0 is never granted.
- Reset (any cycle, including mid-grant) → next edge, regardless of req:
  - state = IDLE, ptr = 0, hold_cnt = 0.
  - grant = 0, sel = 0, gnt_valid = 0, gnt_new = 0.

## Timing
- All outputs are registered; there is no combinational path from req to outputs.
- Request-to-grant latency is 1 cycle: req sampled at edge k gives grant visible after edge k.
- Release-to-handoff is 1 cycle: the owner drops req before edge k, and the new grant is visible after edge k.
- A pre-empted owner sees grant deassert on the same edge the new owner's grant asserts.
- An owner may hold the grant for at most MAX_HOLD cycles while others are waiting.
- Worst-case wait for a continuously asserted request: 15×MAX_HOLD cycles plus 1.
- With MAX_HOLD=1 and all 16 requesting, the grant rotates every cycle and gnt_new stays high continuously.
- Simultaneous owner release and new requests: arbitration uses the current-cycle req only.
- The mux output is valid combinationally from sel in the same cycle the grant appears.

## Test plan
- Reset: reset=1 for 2 cycles with req=16'hFFFF → grant=0, sel=0, gnt_valid=0, gnt_new=0. Release reset → next edge grant=16'h0001, sel=0.
- Single requester: req=16'h0020 → after 1 edge grant=16'h0020, sel=5, gnt_valid=1, gnt_new pulses exactly 1 cycle. Then req=0 → next edge grant=0, gnt_valid=0, sel stays 5.
- Round-robin with wrap: MAX_HOLD=2, req=16'hFFFF held → owners 0,1,...,15,0 in order, each for exactly 2 cycles; gnt_new pulses every 2 cycles.
- Lone holder saturation: MAX_HOLD=4, req=16'h0008 for 20 cycles → grant stays 16'h0008 and gnt_new pulses once only. Then add req[12] → grant moves to 16'h1000 on the next edge.
- Zero-gap handoff: owner 3 (ptr=4), req[3] drops in the same cycle req=16'h0002 → next edge grant=16'h0002, sel=1, gnt_valid stays 1.
- Reset mid-grant: owner 9 with hold_cnt=3, reset pulsed 1 cycle with req=16'h0200 held → outputs at reset values. On the edge after reset releases, grant=16'h0200 and ptr restarts from 0.
